wb_write_ctrl: RTL and testbench
================================

Name: wb_write_ctrl

Overview:
- Initiator side of the register-file write port (dR / wData / wEnable).
- Accepts write-back requests from two producers: the main pipeline (P) and the multi-cycle mult/div unit (M). Arbitrates between them, buffers them in an in-order queue and drives one register-file write per cycle.
- Provides forwarding lookups so read-port consumers see pending, not-yet-committed values.
- Sits between the pipeline write-back stage and the register file.

Parameters:
- DEPTH, 4, queue entries (power of two, ≥2)
- AW, 5, register address width
- DW, 32, data width

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- pValid  in  1  pipeline write request
- pDest  in  AW  pipeline destination register
- pData  in  DW  pipeline write data
- pReady  out  1  pipeline request accepted this cycle
- mValid  in  1  mult/div write request
- mDest  in  AW  mult/div destination register
- mData  in  DW  mult/div write data
- mReady  out  1  mult/div request accepted this cycle
- wStall  in  1  register-file write port unavailable this cycle (debug/test access)
- dR  out  AW  register-file write address
- wData  out  DW  register-file write data
- wEnable  out  1  register-file write strobe
- rA, rB  in  AW  read addresses to check for forwarding
- aHit, bHit  out  1  pending write exists for rA / rB
- aFwd, bFwd  out  DW  youngest pending data for rA / rB
- pending  out  clog2(DEPTH)+1  queue occupancy
- idle  out  1  queue empty

Behaviour:
- Reset (async, nRST=0):
  - read/write pointers and count cleared; all queued writes discarded.
  - wEnable=0, dR=0, wData=0, pending=0, idle=1, aHit=bHit=0, aFwd=bFwd=0.
  - Assertion mid-operation drops every queued entry; none reaches the register file.
- Arbitration:
  - One push per cycle; P has fixed priority over M.
  - pReady = !full.
  - mReady = !full && !pValid.
  - Handshake completes on the rising edge when valid && ready; producers hold request fields until accepted.
- $0 filtering: an accepted request with dest==0 completes its handshake but is not enqueued. Occupancy is unchanged and wEnable is never raised for address 0.
- Commit:
  - Queue head drives dR/wData combinationally.
  - wEnable = !empty && !wStall.
  - The head pops on the same edge on which the register file samples it.
  - Latency: request accepted at edge N is written at edge N+1 when no stall and queue was empty; otherwise strict FIFO order.
- Simultaneous push and pop: allowed in the same cycle, and occupancy is unchanged.
  - A push is not granted when full, even if a pop occurs that cycle (ready does not depend on wStall).
- Full: count==DEPTH, so pReady=mReady=0.
- Empty: wEnable=0 and idle=1. dR/wData hold their last value and are don't-care.
- Pointers: wrap modulo DEPTH. count is an independent counter, so full and empty are unambiguous.
- Forwarding:
  - All valid entries are searched, including the head being committed this cycle, because the register-file read is asynchronous and still holds the old value.
  - The youngest matching entry wins.
  - rA==0 / rB==0 never hits.
  - Requests being pushed this cycle are not visible until the next cycle.
  - Purely combinational from queue state.
- Ordering guarantee: two writes to the same register commit in acceptance order. The last accepted value is final.

Decomposition:
- Shared package: AW/DW defaults, REG_ZERO=0 constant, write-request struct {dest, data}.
- One natural sub-module: wb_queue (DEPTH-entry FIFO with count and parallel entry visibility for the forward search). Arbitration, $0 filter and forward match stay in wb_write_ctrl.

Test Plan:
- Single write, no stall: pValid, pDest=5, pData=0xDEADBEEF at edge 1.
  - Required: dR=5, wData=0xDEADBEEF, wEnable=1 in the following cycle.
  - Required: pending=1 during that cycle, then 0 and idle=1.
- Priority: pValid (dest 3, 0x11) and mValid (dest 4, 0x22) both high.
  - Required: pReady=1 and mReady=0 in cycle 1; M accepted in cycle 2.
  - Required: commits in order r3=0x11, then r4=0x22.
- Fill under stall: wStall=1, push dests 1..4 (data 0xA1..0xA4).
  - Required: pending=4 and pReady=0; a 5th request is held.
  - Release wStall. Required: four consecutive wEnable cycles 1..4, then the 5th request is accepted.
- $0 drop: push dest=0, data=0xFFFFFFFF. Required: pReady=1, pending stays 0, wEnable never asserted.
- Forwarding: wStall=1, push r7=0x10 then r7=0x20, rA=7, rB=0.
  - Required: aHit=1, aFwd=0x20, bHit=0.
  - After draining: aHit=0.
- Reset mid-operation: with 3 entries queued under stall, pulse nRST low asynchronously (between edges).
  - Required: wEnable=0 and pending=0 immediately, and no writes after release.

Source files
------------

// File: rtl/wb_write_ctrl_pkg.sv
// Shared definitions for the register-file write-back controller.
// Default widths, the hard-wired zero register and the queued write-request record.
package wb_write_ctrl_pkg;

  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [AW_DEF-1:0] dest;
    logic [DW_DEF-1:0] data;
  } wbReq_t;

endpackage

// File: rtl/wb_queue.sv
// In-order write queue with occupancy count and an oldest-first view of all entries.
// Head visible combinationally; push is ignored when full and pop is ignored when empty.
module wb_queue
  import wb_write_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          push,
  input  logic [AW-1:0]                 pushDest,
  input  logic [DW-1:0]                 pushData,
  input  logic                          pop,
  output logic [AW-1:0]                 headDest,
  output logic [DW-1:0]                 headData,
  output logic [DEPTH-1:0][AW-1:0]      ageDest,
  output logic [DEPTH-1:0][DW-1:0]      ageData,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][AW-1:0] memDest;
  logic [DEPTH-1:0][DW-1:0] memData;
  logic [PW-1:0]            wrPtr;
  logic [PW-1:0]            rdPtr;
  logic                     doPush;
  logic                     doPop;

  assign full   = (count == (PW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  assign headDest = memDest[rdPtr];
  assign headData = memData[rdPtr];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      memDest <= '0;
      memData <= '0;
    end else begin
      if (doPush) begin
        memDest[wrPtr] <= pushDest;
        memData[wrPtr] <= pushData;
        wrPtr          <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (doPush && !doPop) begin
        count <= count + 1'b1;
      end else if (!doPush && doPop) begin
        count <= count - 1'b1;
      end
    end
  end

  // Index 0 is the oldest entry; pointer arithmetic wraps because DEPTH is a power of two.
  always_comb begin
    ageDest = '0;
    ageData = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ageDest[k] = memDest[rdPtr + PW'(k)];
      ageData[k] = memData[rdPtr + PW'(k)];
    end
  end

endmodule

// File: rtl/wb_write_ctrl.sv
// Write-back arbiter (P over M), queue and forwarding search in front of the register-file write port.
// Accepted write commits one edge later when unstalled; requests are refused while the queue is full.
module wb_write_ctrl
  import wb_write_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   pValid,
  input  logic [AW-1:0]          pDest,
  input  logic [DW-1:0]          pData,
  output logic                   pReady,
  input  logic                   mValid,
  input  logic [AW-1:0]          mDest,
  input  logic [DW-1:0]          mData,
  output logic                   mReady,
  input  logic                   wStall,
  output logic [AW-1:0]          dR,
  output logic [DW-1:0]          wData,
  output logic                   wEnable,
  input  logic [AW-1:0]          rA,
  input  logic [AW-1:0]          rB,
  output logic                   aHit,
  output logic                   bHit,
  output logic [DW-1:0]          aFwd,
  output logic [DW-1:0]          bFwd,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   idle
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                     full;
  logic                     empty;
  logic                     pFire;
  logic                     mFire;
  logic                     push;
  logic [AW-1:0]            selDest;
  logic [DW-1:0]            selData;
  logic [DEPTH-1:0][AW-1:0] ageDest;
  logic [DEPTH-1:0][DW-1:0] ageData;

  assign pReady  = !full;
  assign mReady  = !full && !pValid;
  assign pFire   = pValid && pReady;
  assign mFire   = mValid && mReady;
  assign selDest = pFire ? pDest : mDest;
  assign selData = pFire ? pData : mData;
  // Writes to the zero register complete the handshake but never occupy a slot.
  assign push    = (pFire || mFire) && (selDest != AW'(REG_ZERO));

  assign wEnable = !empty && !wStall;
  assign idle    = empty;

  wb_queue #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) uQueue (
    .CLK      (CLK),
    .nRST     (nRST),
    .push     (push),
    .pushDest (selDest),
    .pushData (selData),
    .pop      (wEnable),
    .headDest (dR),
    .headData (wData),
    .ageDest  (ageDest),
    .ageData  (ageData),
    .count    (pending),
    .full     (full),
    .empty    (empty)
  );

  // Oldest-to-youngest scan so the last match (youngest) wins; the committing head is included.
  always_comb begin
    aHit = 1'b0;
    bHit = 1'b0;
    aFwd = '0;
    bFwd = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < pending) begin
        if ((rA != AW'(REG_ZERO)) && (ageDest[k] == rA)) begin
          aHit = 1'b1;
          aFwd = ageData[k];
        end
        if ((rB != AW'(REG_ZERO)) && (ageDest[k] == rB)) begin
          bHit = 1'b1;
          bFwd = ageData[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_ctrl.sv
// Directed bench for wb_write_ctrl: queue-level reference model checked every cycle plus literal checkpoints.
module tb_wb_write_ctrl;
  import wb_write_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          pValid, mValid, wStall;
  logic [AW-1:0] pDest, mDest, rA, rB;
  logic [DW-1:0] pData, mData;
  logic          pReady, mReady, wEnable, aHit, bHit, idle;
  logic [AW-1:0] dR;
  logic [DW-1:0] wData, aFwd, bFwd;
  logic [2:0]    pending;

  int nChecks = 0;
  int nFail   = 0;
  int writesAfterReset;
  bit countWrites = 1'b0;

  wbReq_t mq[$];

  wb_write_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .pValid(pValid), .pDest(pDest), .pData(pData), .pReady(pReady),
    .mValid(mValid), .mDest(mDest), .mData(mData), .mReady(mReady),
    .wStall(wStall), .dR(dR), .wData(wData), .wEnable(wEnable),
    .rA(rA), .rB(rB), .aHit(aHit), .bHit(bHit), .aFwd(aFwd), .bFwd(bFwd),
    .pending(pending), .idle(idle)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: a plain queue of accepted non-zero writes.
  always @(negedge nRST) mq.delete();

  always @(posedge CLK) begin
    bit     wasFull;
    wbReq_t r;
    if (nRST) begin
      wasFull = (mq.size() >= DEPTH);
      if (mq.size() > 0 && !wStall) void'(mq.pop_front());
      if (!wasFull && (pValid || mValid)) begin
        r.dest = pValid ? pDest : mDest;
        r.data = pValid ? pData : mData;
        if (r.dest != 0) mq.push_back(r);
      end
    end
  end

  always @(posedge CLK) begin
    if (countWrites && wEnable) writesAfterReset++;
  end

  always @(negedge CLK) begin
    bit            eaHit, ebHit;
    logic [DW-1:0] eaFwd, ebFwd;
    if (nRST) begin
      chk("m_pReady", pReady, 32'(mq.size() < DEPTH));
      chk("m_mReady", mReady, 32'((mq.size() < DEPTH) && !pValid));
      chk("m_wEnable", wEnable, 32'((mq.size() > 0) && !wStall));
      chk("m_pending", pending, mq.size());
      chk("m_idle", idle, 32'(mq.size() == 0));
      if (mq.size() > 0) begin
        chk("m_dR", dR, mq[0].dest);
        chk("m_wData", wData, mq[0].data);
      end
      eaHit = 0; ebHit = 0; eaFwd = '0; ebFwd = '0;
      foreach (mq[i]) begin
        if (rA != 0 && mq[i].dest == rA) begin eaHit = 1; eaFwd = mq[i].data; end
        if (rB != 0 && mq[i].dest == rB) begin ebHit = 1; ebFwd = mq[i].data; end
      end
      chk("m_aHit", aHit, eaHit);
      chk("m_bHit", bHit, ebHit);
      chk("m_aFwd", aFwd, eaFwd);
      chk("m_bFwd", bFwd, ebFwd);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pReq(input logic [AW-1:0] d, input logic [DW-1:0] v);
    pValid = 1'b1; pDest = d; pData = v;
  endtask

  initial begin
    nRST = 1'b0; pValid = 0; mValid = 0; wStall = 0;
    pDest = '0; pData = '0; mDest = '0; mData = '0; rA = '0; rB = '0;
    #2;
    chk("rst_wEnable", wEnable, 0);
    chk("rst_pending", pending, 0);
    chk("rst_idle", idle, 1);
    chk("rst_dR", dR, 0);
    chk("rst_wData", wData, 0);
    chk("rst_aHit", aHit, 0);
    tick();
    nRST = 1'b1;
    tick();

    // Single write
    pReq(5'd5, 32'hDEADBEEF);
    @(negedge CLK); chk("s_pReady", pReady, 1);
    tick(); pValid = 0;
    @(negedge CLK);
    chk("s_wEnable", wEnable, 1); chk("s_dR", dR, 5);
    chk("s_wData", wData, 32'hDEADBEEF); chk("s_pending", pending, 1);
    tick();
    @(negedge CLK); chk("s_pending0", pending, 0); chk("s_idle", idle, 1);

    // Priority P over M
    tick();
    pReq(5'd3, 32'h11);
    mValid = 1; mDest = 5'd4; mData = 32'h22;
    @(negedge CLK); chk("p_pReady", pReady, 1); chk("p_mReady", mReady, 0);
    tick(); pValid = 0;
    @(negedge CLK); chk("p_mReady2", mReady, 1);
    chk("p_dR3", dR, 3); chk("p_wData11", wData, 32'h11);
    tick(); mValid = 0;
    @(negedge CLK); chk("p_dR4", dR, 4); chk("p_wData22", wData, 32'h22);
    chk("p_wEn4", wEnable, 1);
    tick();

    // Fill under stall, then drain
    wStall = 1;
    for (int i = 1; i <= 4; i++) begin
      pReq(AW'(i), 32'hA0 + 32'(i));
      tick();
    end
    pReq(5'd9, 32'hB5);
    @(negedge CLK); chk("f_pending4", pending, 4); chk("f_pReady0", pReady, 0);
    tick();
    @(negedge CLK); chk("f_held", pReady, 0);
    tick(); wStall = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      chk("f_wEn", wEnable, 1); chk("f_dR", dR, i); chk("f_wData", wData, 32'hA0 + 32'(i));
      if (i == 1) chk("f_rdyFull", pReady, 0);
      if (i == 2) chk("f_rdyFree", pReady, 1);
      tick();
      if (i == 2) pValid = 0;
    end
    @(negedge CLK); chk("f_fifth_dR", dR, 9); chk("f_fifth_dat", wData, 32'hB5);
    chk("f_fifth_pend", pending, 1);
    tick();

    // Zero-register drop
    pReq(5'd0, 32'hFFFFFFFF);
    @(negedge CLK); chk("z_pReady", pReady, 1);
    tick(); pValid = 0;
    @(negedge CLK); chk("z_pending", pending, 0); chk("z_wEnable", wEnable, 0);
    tick();

    // Forwarding, youngest wins
    wStall = 1;
    pReq(5'd7, 32'h10); tick();
    pReq(5'd7, 32'h20); rA = 5'd7; rB = 5'd0;
    @(negedge CLK); chk("w_aFwdOld", aFwd, 32'h10);
    tick(); pValid = 0;
    @(negedge CLK); chk("w_aHit", aHit, 1); chk("w_aFwd", aFwd, 32'h20); chk("w_bHit", bHit, 0);
    tick(); wStall = 0;
    tick(); tick();
    @(negedge CLK); chk("w_aHitDrain", aHit, 0); chk("w_idle", idle, 1);
    tick(); rA = 0;

    // Async reset mid-operation
    wStall = 1;
    for (int i = 10; i <= 12; i++) begin
      pReq(AW'(i), 32'(i) * 32'h101);
      tick();
    end
    pValid = 0;
    @(negedge CLK); chk("r_pending3", pending, 3);
    tick(); #2;
    nRST = 0; #1;
    chk("r_wEnable", wEnable, 0); chk("r_pending", pending, 0); chk("r_idle", idle, 1);
    nRST = 1;
    wStall = 0;
    writesAfterReset = 0; countWrites = 1;
    repeat (5) tick();
    countWrites = 0;
    chk("r_noWrites", writesAfterReset, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
